// File: rtl/connect4_pkg.sv
// Shared definitions for the 4x4 Connect-4 turn controller.
//   - game_status codes returned by the winner detector
//   - board geometry and the cell-index helper (bit = 4*row + col, row 0 = bottom)
//   - controller state encoding
package connect4_pkg;

    localparam int BOARD_W = 16;
    localparam int COLS    = 4;
    localparam int ROWS    = 4;

    localparam logic [1:0] ST_PLAYING = 2'b00;
    localparam logic [1:0] ST_P1      = 2'b01;
    localparam logic [1:0] ST_P2      = 2'b10;
    localparam logic [1:0] ST_TIE     = 2'b11;

    localparam logic [4:0] MAX_MOVES = 5'd16;

    typedef enum logic [2:0] {
        S_CLEAR     = 3'd0,
        S_WAIT_MOVE = 3'd1,
        S_SCAN      = 3'd2,
        S_PLACE     = 3'd3,
        S_CHECK     = 3'd4,
        S_OVER      = 3'd5
    } state_e;

    // Row-major cell index: {row, col} is exactly 4*row + col on a 4-wide board.
    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/connect4_turn_timer.sv
// Turn-timeout counter for the Connect-4 controller.
//   clk, reset  : clock, asynchronous active-high reset
//   clear_i     : zero the counter
//   enable_i    : count this cycle (player is being waited on)
//   hold_i      : a move is being accepted this cycle; suppresses expiry
//   expire_o    : combinational one-cycle expiry strobe; counter self-clears on it
// With TURN_TIMEOUT = 0 the counter never leaves zero and expire_o is constant 0.
module connect4_turn_timer #(
    parameter int TURN_TIMEOUT = 0,
    parameter int TO_W         = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    input  logic hold_i,
    output logic expire_o
);

    localparam bit            TIMER_ON = (TURN_TIMEOUT != 0);
    localparam logic [TO_W-1:0] LIMIT  = TO_W'(TIMER_ON ? TURN_TIMEOUT - 1 : 0);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // The counter parks at LIMIT: if a move is accepted exactly at the limit and
    // then rejected, the turn expires on the next idle waiting cycle.
    assign expire_o = TIMER_ON && enable_i && !hold_i && (cnt_q == LIMIT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (enable_i && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 (4x4, two players) turn sequencer. Owns the board registers, applies
// gravity to column drops, alternates turns and consults an external winner
// detector (game_status) after each placed disc.
//   clk, reset          : clock, asynchronous active-high reset
//   new_game            : synchronous clear, highest priority
//   drop_valid/drop_col : column-drop request; accepted when drop_ready is high
//   drop_ready          : high while waiting for a move
//   game_status         : detector result (00 playing, 01 P1, 10 P2, 11 tie)
//   game_board          : occupancy, bit = 4*row + col, row 0 = bottom
//   player_cells        : owner per cell, 0 = P1, 1 = P2
//   cur_player          : player to move
//   move_ack/move_reject/timeout_pass : registered, mutually exclusive pulses
//   game_over           : high in OVER
//   move_count          : discs placed, saturates at 16
module connect4_turn_ctrl
    import connect4_pkg::*;
#(
    parameter int CHECK_WAIT   = 2,
    parameter int TURN_TIMEOUT = 0,
    parameter int TO_W         = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         new_game,
    input  logic         drop_valid,
    input  logic [1:0]   drop_col,
    output logic         drop_ready,
    input  logic [1:0]   game_status,
    output logic [15:0]  game_board,
    output logic [15:0]  player_cells,
    output logic         cur_player,
    output logic         move_ack,
    output logic         move_reject,
    output logic         timeout_pass,
    output logic         game_over,
    output logic [4:0]   move_count
);

    localparam logic [7:0] CHK_LAST = 8'(CHECK_WAIT - 1);

    state_e               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [BOARD_W-1:0]   cells_q, cells_d;
    logic                 player_q, player_d;
    logic [4:0]           count_q, count_d;
    logic [1:0]           col_q, col_d;
    logic [1:0]           row_q, row_d;
    logic [7:0]           chk_q, chk_d;
    logic                 ack_q, ack_d;
    logic                 rej_q, rej_d;
    logic                 pass_q, pass_d;
    logic                 ready_q, ready_d;

    logic                 handshake;
    logic                 timer_clr;
    logic                 timer_expire;
    logic [3:0]           idx;

    assign handshake = drop_valid && ready_q;
    assign idx       = cell_idx(row_q, col_q);

    connect4_turn_timer #(
        .TURN_TIMEOUT (TURN_TIMEOUT),
        .TO_W         (TO_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clr),
        .enable_i (state_q == S_WAIT_MOVE),
        .hold_i   (handshake),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cells_d   = cells_q;
        player_d  = player_q;
        count_d   = count_q;
        col_d     = col_q;
        row_d     = row_q;
        chk_d     = chk_q;
        ack_d     = 1'b0;
        rej_d     = 1'b0;
        pass_d    = 1'b0;
        timer_clr = 1'b0;

        case (state_q)
            S_CLEAR: state_d = S_WAIT_MOVE;

            S_WAIT_MOVE: begin
                if (handshake) begin
                    col_d   = drop_col;
                    row_d   = '0;
                    state_d = S_SCAN;
                end else if (timer_expire) begin
                    pass_d   = 1'b1;
                    player_d = ~player_q;
                end
            end

            // Gravity: walk up the column one row per cycle until an empty cell.
            S_SCAN: begin
                if (!board_q[idx]) begin
                    state_d = S_PLACE;
                end else if (row_q == 2'(ROWS - 1)) begin
                    rej_d   = 1'b1;
                    state_d = S_WAIT_MOVE;
                end else begin
                    row_d = row_q + 2'd1;
                end
            end

            S_PLACE: begin
                board_d[idx] = 1'b1;
                cells_d[idx] = player_q;
                count_d      = (count_q == MAX_MOVES) ? MAX_MOVES : count_q + 5'd1;
                ack_d        = 1'b1;
                timer_clr    = 1'b1;
                chk_d        = '0;
                state_d      = S_CHECK;
            end

            // Give the detector time to see the new board before trusting its verdict.
            S_CHECK: begin
                if (chk_q == CHK_LAST) begin
                    if (game_status != ST_PLAYING || count_q == MAX_MOVES) begin
                        state_d = S_OVER;
                    end else begin
                        player_d = ~player_q;
                        state_d  = S_WAIT_MOVE;
                    end
                end else begin
                    chk_d = chk_q + 8'd1;
                end
            end

            S_OVER: state_d = S_OVER;

            default: state_d = S_WAIT_MOVE;
        endcase

        // new_game overrides whatever the FSM decided, discarding any pending move.
        if (new_game) begin
            state_d   = S_CLEAR;
            board_d   = '0;
            cells_d   = '0;
            player_d  = 1'b0;
            count_d   = '0;
            col_d     = '0;
            row_d     = '0;
            chk_d     = '0;
            ack_d     = 1'b0;
            rej_d     = 1'b0;
            pass_d    = 1'b0;
            timer_clr = 1'b1;
        end

        // Registered ready keeps drop_ready low out of reset even though the FSM idles in WAIT_MOVE.
        ready_d = (state_d == S_WAIT_MOVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT_MOVE;
            board_q  <= '0;
            cells_q  <= '0;
            player_q <= 1'b0;
            count_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            chk_q    <= '0;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            pass_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cells_q  <= cells_d;
            player_q <= player_d;
            count_q  <= count_d;
            col_q    <= col_d;
            row_q    <= row_d;
            chk_q    <= chk_d;
            ack_q    <= ack_d;
            rej_q    <= rej_d;
            pass_q   <= pass_d;
            ready_q  <= ready_d;
        end
    end

    assign drop_ready   = ready_q;
    assign game_board   = board_q;
    assign player_cells = cells_q;
    assign cur_player   = player_q;
    assign move_ack     = ack_q;
    assign move_reject  = rej_q;
    assign timeout_pass = pass_q;
    assign game_over    = (state_q == S_OVER);
    assign move_count   = count_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Bench for connect4_turn_ctrl: one instance without timeout for game play,
// one with TURN_TIMEOUT=10 for the forfeit behaviour. Game rules are modelled
// with column heights and an owner grid.
module tb_connect4_turn_ctrl;

    localparam int TO_CYC = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        new_game, drop_valid;
    logic [1:0]  drop_col;
    logic        drop_ready;
    logic [1:0]  game_status;
    logic [15:0] game_board, player_cells;
    logic        cur_player, move_ack, move_reject, timeout_pass, game_over;
    logic [4:0]  move_count;
    logic        force_zero;

    logic        t_new_game, t_drop_valid;
    logic [1:0]  t_drop_col;
    logic        t_drop_ready;
    logic [1:0]  t_game_status;
    logic [15:0] t_game_board, t_player_cells;
    logic        t_cur_player, t_move_ack, t_move_reject, t_timeout_pass, t_game_over;
    logic [4:0]  t_move_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Winner detector environment: any full line of one owner wins, full board ties.
    function automatic logic [1:0] detect(input logic [15:0] b, input logic [15:0] c);
        logic [1:0] res;
        int start, step, i;
        logic full_line, all1, all0;
        res = 2'b00;
        for (int l = 0; l < 10; l++) begin
            if (l < 4)       begin start = 4 * l; step = 1; end
            else if (l < 8)  begin start = l - 4; step = 4; end
            else if (l == 8) begin start = 0;     step = 5; end
            else             begin start = 3;     step = 3; end
            full_line = 1'b1; all1 = 1'b1; all0 = 1'b1;
            for (int k = 0; k < 4; k++) begin
                i = start + k * step;
                full_line = full_line & b[i];
                all1      = all1 & c[i];
                all0      = all0 & ~c[i];
            end
            if (full_line && all0) res = 2'b01;
            else if (full_line && all1 && res == 2'b00) res = 2'b10;
        end
        if (res == 2'b00 && b == 16'hFFFF) res = 2'b11;
        return res;
    endfunction

    assign game_status   = force_zero ? 2'b00 : detect(game_board, player_cells);
    assign t_game_status = 2'b00;

    connect4_turn_ctrl #(.CHECK_WAIT(2), .TURN_TIMEOUT(0), .TO_W(24)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .drop_valid(drop_valid),
        .drop_col(drop_col), .drop_ready(drop_ready), .game_status(game_status),
        .game_board(game_board), .player_cells(player_cells), .cur_player(cur_player),
        .move_ack(move_ack), .move_reject(move_reject), .timeout_pass(timeout_pass),
        .game_over(game_over), .move_count(move_count)
    );

    connect4_turn_ctrl #(.CHECK_WAIT(2), .TURN_TIMEOUT(TO_CYC), .TO_W(24)) dut_to (
        .clk(clk), .reset(reset), .new_game(t_new_game), .drop_valid(t_drop_valid),
        .drop_col(t_drop_col), .drop_ready(t_drop_ready), .game_status(t_game_status),
        .game_board(t_game_board), .player_cells(t_player_cells), .cur_player(t_cur_player),
        .move_ack(t_move_ack), .move_reject(t_move_reject), .timeout_pass(t_timeout_pass),
        .game_over(t_game_over), .move_count(t_move_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_h[4];
    bit m_occ[16];
    bit m_own[16];
    int m_turn, m_moves;
    bit m_over;

    task automatic m_reset();
        for (int c = 0; c < 4; c++) m_h[c] = 0;
        for (int i = 0; i < 16; i++) begin m_occ[i] = 0; m_own[i] = 0; end
        m_turn = 0; m_moves = 0; m_over = 0;
    endtask

    function automatic logic [15:0] m_board();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic logic [15:0] m_cells();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_occ[i] & m_own[i];
        return v;
    endfunction

    task automatic compare_state(input string tag);
        check({tag, "_board"}, game_board, m_board());
        check({tag, "_cells"}, player_cells & game_board, m_cells());
        check({tag, "_count"}, move_count, m_moves);
        check({tag, "_player"}, cur_player, m_turn);
        check({tag, "_over"}, game_over, m_over);
        check({tag, "_pass"}, timeout_pass, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, drop_ready, 0);
        check({tag, "_board"}, game_board, 0);
        check({tag, "_cells"}, player_cells, 0);
        check({tag, "_player"}, cur_player, 0);
        check({tag, "_pulses"}, {move_ack, move_reject, timeout_pass}, 0);
        check({tag, "_over"}, game_over, 0);
        check({tag, "_count"}, move_count, 0);
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!drop_ready && t < 50) begin @(negedge clk); t++; end
        check({tag, "_ready_wait"}, drop_ready, 1);
    endtask

    task automatic start_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_reset();
        check_all_zero("ng_clear");
        @(negedge clk);
        check("ng_ready", drop_ready, 1);
    endtask

    // Drop while the game is over: must be ignored entirely.
    task automatic ignored_drop(input int c);
        bit seen = 0;
        drop_valid = 1'b1;
        drop_col   = 2'(c);
        repeat (5) begin
            @(negedge clk);
            if (move_ack || move_reject) seen = 1;
        end
        drop_valid = 1'b0;
        check("over_ready", drop_ready, 0);
        check("over_nopulse", seen, 0);
        compare_state("over");
    endtask

    task automatic do_drop(input int c);
        int k, exp_k, row, t;
        bit full;
        if (m_over) begin
            ignored_drop(c);
            return;
        end
        wait_ready("drop");
        drop_valid = 1'b1;
        drop_col   = 2'(c);
        @(negedge clk);
        drop_valid = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (move_ack || move_reject) break;
        end
        full  = (m_h[c] == 4);
        row   = m_h[c];
        exp_k = full ? 4 : row + 2;
        check("latency", k, exp_k);
        check("ack", move_ack, !full);
        check("reject", move_reject, full);
        if (!full) begin
            m_occ[4 * row + c] = 1;
            m_own[4 * row + c] = m_turn[0];
            m_h[c]++;
            m_moves++;
            m_over = (!force_zero && detect(m_board(), m_cells()) != 2'b00) || (m_moves == 16);
            if (!m_over) m_turn ^= 1;
            @(negedge clk);
            check("ack_pulse_width", move_ack, 0);
        end
        t = 0;
        while (!drop_ready && !game_over && t < 20) begin @(negedge clk); t++; end
        check("settle", drop_ready | game_over, 1);
        compare_state("move");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int j, first_pass, second_pass, npass, t;
        bit acked, passed;

        reset = 1'b1; new_game = 1'b0; drop_valid = 1'b0; drop_col = 2'd0; force_zero = 1'b0;
        t_new_game = 1'b0; t_drop_valid = 1'b0; t_drop_col = 2'd0;
        m_reset();
        #1;
        check_all_zero("reset");
        #33;
        reset = 1'b0;

        // Column fill and overflow.
        start_new_game();
        for (int i = 0; i < 4; i++) do_drop(0);
        check("col_board", game_board, 16'h1111);
        check("col_cells", player_cells & game_board, 16'h1010);
        do_drop(0);
        check("col_reject_player", cur_player, 0);
        check("col_reject_board", game_board, 16'h1111);

        // Horizontal P1 win on the bottom row after seven drops.
        start_new_game();
        begin
            int seq[7] = '{0, 0, 1, 1, 2, 2, 3};
            foreach (seq[i]) do_drop(seq[i]);
        end
        check("win_over", game_over, 1);
        check("win_count", move_count, 7);
        check("win_status", game_status, 2'b01);
        do_drop(1);

        // Random full game with the detector held at PLAYING: ends on the 16th disc.
        force_zero = 1'b1;
        start_new_game();
        for (int i = 0; i < 60 && !m_over; i++) do_drop($urandom_range(0, 3));
        check("full_over", game_over, 1);
        check("full_count", move_count, 16);
        do_drop(2);
        force_zero = 1'b0;

        // Randomized games with the live detector.
        for (int g = 0; g < 6; g++) begin
            start_new_game();
            for (int i = 0; i < 24 && !m_over; i++) do_drop($urandom_range(0, 3));
            if (m_over) do_drop($urandom_range(0, 3));
        end

        // new_game during SCAN.
        start_new_game();
        do_drop(0); do_drop(0);
        wait_ready("scan");
        drop_valid = 1'b1; drop_col = 2'd0;
        @(negedge clk);
        drop_valid = 1'b0; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_reset();
        check("ng_scan_ack", move_ack | move_reject, 0);
        check_all_zero("ng_scan");
        @(negedge clk);
        check("ng_scan_ready", drop_ready, 1);
        check("ng_scan_ack2", move_ack, 0);

        // new_game during CHECK.
        do_drop(3);
        wait_ready("check");
        drop_valid = 1'b1; drop_col = 2'd1;
        @(negedge clk);
        drop_valid = 1'b0;
        t = 0;
        while (!move_ack && t < 8) begin @(negedge clk); t++; end
        check("ng_check_ack_seen", move_ack, 1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_reset();
        check_all_zero("ng_check");
        @(negedge clk);
        check("ng_check_ready", drop_ready, 1);

        // Asynchronous reset while in PLACE, between clock edges.
        do_drop(0);
        wait_ready("place");
        drop_valid = 1'b1; drop_col = 2'd1;
        @(negedge clk);
        drop_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #3 reset = 1'b0;
        m_reset();
        do_drop(2);
        do_drop(2);
        do_drop(1);

        // Timeout: forfeit after the 10th waiting cycle, twice.
        @(negedge clk);
        t_new_game = 1'b1;
        @(negedge clk);
        t_new_game = 1'b0;
        first_pass = 0; second_pass = 0; npass = 0;
        for (j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (t_timeout_pass) begin
                npass++;
                if (npass == 1) begin
                    first_pass = j;
                    check("to_player_1", t_cur_player, 1);
                end else if (npass == 2) begin
                    second_pass = j;
                    check("to_player_2", t_cur_player, 0);
                end
            end
        end
        check("to_first", first_pass, TO_CYC + 1);
        check("to_second", second_pass, 2 * TO_CYC + 1);
        check("to_npass", npass, 2);

        // Handshake in the expiry cycle wins.
        @(negedge clk);
        t_new_game = 1'b1;
        @(negedge clk);
        t_new_game = 1'b0;
        repeat (TO_CYC - 1) @(negedge clk);
        @(negedge clk);
        check("to_hs_ready", t_drop_ready, 1);
        t_drop_valid = 1'b1; t_drop_col = 2'd2;
        @(negedge clk);
        t_drop_valid = 1'b0;
        acked = 0; passed = 0;
        for (int i = 0; i < 8; i++) begin
            if (t_move_ack) acked = 1;
            if (t_timeout_pass) passed = 1;
            @(negedge clk);
        end
        check("to_hs_ack", acked, 1);
        check("to_hs_nopass", passed, 0);
        check("to_hs_player", t_cur_player, 1);
        check("to_hs_board", t_game_board, 16'h0004);
        check("to_hs_count", t_move_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
